// File: rtl/nrzi_rx_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_rx_decoder_if
//  Description : Byte stream from the NRZI receive decoder to its consumer.
//                master = byte producer (decoder), slave = consumer.
//  Signals     : out_data  - received byte, bit0 = first received bit
//                out_valid - out_data holds a byte
//                out_ready - consumer accepts when out_valid && out_ready
//                out_last  - byte is the final byte of its frame
//  Revision    : 1.0 - initial release
// ============================================================================
interface nrzi_rx_decoder_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/nrzi_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_rx_decoder
//  Description : NRZI receive decoder. Recovers bits from line transitions,
//                removes stuffed 1s, hunts for the SYNC byte and assembles
//                fixed-length frames presented on a valid/ready byte port.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                line_in    - NRZI line level (already synchronised)
//                line_valid - sample strobe for line_in
//                bus        - byte stream (master modport)
//                in_frame   - high while assembling frame payload
//                stuff_err  - one-cycle pulse on stuffing violation in frame
//                overflow   - one-cycle pulse when a completed byte is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module nrzi_rx_decoder #(
    parameter logic [7:0] SYNC        = 8'hD5,
    parameter int         STUFF_LEN   = 5,
    parameter int         FRAME_BYTES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             line_in,
    input  wire logic             line_valid,
    nrzi_rx_decoder_if.master     bus,
    output logic                  in_frame,
    output logic                  stuff_err,
    output logic                  overflow
);

    localparam logic [2:0] c_stuff_len   = 3'(STUFF_LEN);
    localparam logic [7:0] c_frame_bytes = 8'(FRAME_BYTES);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_line_q;
    logic [7:0] r_sr;
    logic [2:0] r_zero_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte_cnt;
    logic       r_stuff_err;
    logic       r_overflow;

    logic       w_bit;
    logic       w_stuff_slot;
    logic [7:0] w_sr_next;
    logic [7:0] w_byte_cnt_next;
    logic       w_last_byte;
    logic       w_out_free;

    always_comb begin
        w_bit           = line_in ^ r_line_q;
        // After STUFF_LEN consecutive zeros the next bit is inserted by the
        // transmitter and never carries data.
        w_stuff_slot    = (r_zero_cnt == c_stuff_len);
        w_sr_next       = {w_bit, r_sr[7:1]};
        w_byte_cnt_next = r_byte_cnt + 8'd1;
        w_last_byte     = (w_byte_cnt_next == c_frame_bytes);
        // Holding register can take a new byte if empty or draining now.
        w_out_free      = !bus.out_valid || bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_line_q      <= 1'b0;
            r_sr          <= '0;
            r_zero_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_stuff_err   <= 1'b0;
            r_overflow    <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            r_stuff_err <= 1'b0;
            r_overflow  <= 1'b0;

            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (line_valid) begin
                r_line_q <= line_in;

                if (w_stuff_slot) begin
                    r_zero_cnt <= '0;
                    // A zero where a stuffed 1 belongs aborts the frame; the
                    // partial byte is discarded but a held byte is kept.
                    if (!w_bit && (r_state == ST_DATA)) begin
                        r_stuff_err <= 1'b1;
                        r_state     <= ST_HUNT;
                        r_sr        <= '0;
                        r_bit_cnt   <= '0;
                        r_byte_cnt  <= '0;
                    end
                end else begin
                    r_zero_cnt <= w_bit ? 3'd0 : r_zero_cnt + 3'd1;
                    r_sr       <= w_sr_next;

                    if (r_state == ST_HUNT) begin
                        if (w_sr_next == SYNC) begin
                            r_state    <= ST_DATA;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                        end
                    end else if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= w_byte_cnt_next;
                        if (w_out_free) begin
                            bus.out_data  <= w_sr_next;
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= w_last_byte;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        // Frame ends after the final byte whether or not it
                        // could be delivered.
                        if (w_last_byte) begin
                            r_state <= ST_HUNT;
                            r_sr    <= '0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
            end
        end
    end

    assign in_frame  = (r_state == ST_DATA);
    assign stuff_err = r_stuff_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
- Receive end of the team's toggle-encoded (NRZI) serial link.
- The transmitter drives a line level that toggles for every 1 bit (T = bit, line = T-flop output). This block does the reverse conversion: it recovers bits from the line transitions.
- It removes stuffed bits, hunts for a sync byte, then assembles fixed-length frames of bytes.
- Bytes are presented on a valid/ready output port toward the downstream consumer.

Parameters:
- SYNC, 8'hD5: sync byte, received LSB first, that starts a frame.
- STUFF_LEN, 5: number of consecutive decoded 0s after which the transmitter inserts a stuffed 1 (range 2..7).
- FRAME_BYTES, 4: payload bytes per frame after SYNC (range 1..255).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- line_in, input, 1: NRZI line level, already synchronised to clk.
- line_valid, input, 1: sample strobe; line_in is consumed only on cycles where this is 1.
- out_data, output, 8: received byte, bit0 = first received bit.
- out_valid, output, 1: out_data holds a byte.
- out_ready, input, 1: consumer accepts the byte when out_valid && out_ready.
- out_last, output, 1: qualifies out_data as the final byte of the frame.
- in_frame, output, 1: high while in the DATA state.
- stuff_err, output, 1: one-cycle pulse on a stuffing violation in DATA.
- overflow, output, 1: one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - line_q=0, state=HUNT, shift reg=0, zero_cnt=0, bit_cnt=0, byte_cnt=0.
  - out_valid=0, out_last=0, out_data=0, in_frame=0, stuff_err=0, overflow=0.
  - Reset mid-frame discards the partial byte and any held byte.
- Decode, only on line_valid=1:
  - bit = line_in XOR line_q, then line_q <= line_in.
  - No strobe means no state change, except the output handshake.
- Destuffing, applied in both states:
  - zero_cnt counts consecutive decoded 0s and clears on any 1.
  - When zero_cnt == STUFF_LEN, the next decoded bit is a stuff bit.
  - Stuff bit = 1: discard it, zero_cnt <= 0.
  - Stuff bit = 0: violation. In DATA, pulse stuff_err, go to HUNT, discard the partial byte. In HUNT, just set zero_cnt <= 0.
  - Stuff bits are never shifted into data.
- HUNT state:
  - Each non-stuff bit shifts in: sr <= {bit, sr[7:1]}.
  - When the updated sr == SYNC, go to DATA at the same edge, with bit_cnt=0 and byte_cnt=0.
  - in_frame=1 from the next cycle.
- DATA state:
  - Non-stuff bits shift into sr; bit_cnt increments 0..7.
  - On the 8th bit, the byte is complete: bit_cnt <= 0 and byte_cnt increments.
  - Completed byte with the holding register empty, or emptying this same cycle (out_valid && out_ready): load out_data and set out_valid=1 on the next cycle. out_last=1 if it is byte FRAME_BYTES.
  - Completed byte with the register full and not emptying: drop the new byte, pulse overflow, keep the held byte.
  - After byte FRAME_BYTES completes, whether loaded or dropped: go to HUNT, sr <= 0, in_frame=0 next cycle.
- Output holding register:
  - out_valid falls after handshake unless a new byte loads at the same edge.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - A held byte survives the return to HUNT and a stuff_err abort.
- Latency: out_valid rises exactly 1 clk after the edge on which the 8th data bit's strobe is sampled.

Test Plan:
- Reset, then encode SYNC=D5 followed by bytes 11,22,33,44, with line_valid held at 1 and out_ready=1.
  - Required: four out_valid pulses with out_data 11,22,33,44.
  - out_last=1 only on 44.
  - in_frame drops after 44; no stuff_err or overflow.
- Payload byte 00 00 (16 zeros) sent with the transmitter stuffing a 1 after every 5 zeros.
  - Required: out_data=00 twice; the stuffed bits are absent from the output.
- After 5 zeros in DATA, send a 0 in the stuff slot.
  - Required: stuff_err pulses once, in_frame=0 next cycle, no byte output for the partial byte.
  - A following SYNC plus frame is received normally.
- Hold out_ready=0 through a full frame of A1,B2,C3,D4.
  - Required: out_data stays A1 with out_valid=1.
  - overflow pulses 3 times.
  - Raising out_ready then yields A1 only.
- line_valid asserted every 3rd cycle with a full frame.
  - Required: same bytes as the first test.
  - out_valid rises exactly 1 clk after the strobe of each 8th bit.
- Assert rst for 1 cycle midway through byte 2.
  - Required: all outputs 0 next cycle.
  - The resumed line is ignored until a fresh SYNC.
  - Note: line_q=0 after reset, so the first bit after reset decodes relative to level 0.
